// File: rtl/fft_pkg.sv
// Shared FFT definitions for the compff4 front end and its neighbours.
package fft_pkg;
  localparam int SAMPLE_W = 16;
  localparam int FFT_N    = 4;
  localparam int FFT4_LAT = 2;   // compff4 pipeline depth, ce -> y valid

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } cplx_t;
endpackage

// File: rtl/fft4_input_framer_if.sv
// Sample stream in, parallel FFT frame out, plus status.
interface fft4_input_framer_if #(parameter int SAMPLE_W = fft_pkg::SAMPLE_W);
  logic                       s_valid, s_ready, s_last;
  logic signed [SAMPLE_W-1:0] s_re, s_im;
  logic                       m_ready;
  logic signed [SAMPLE_W-1:0] xa1, xa2, xa3, xa4;
  logic signed [SAMPLE_W-1:0] imga1, imga2, imga3, imga4;
  logic                       fft_ce, fft_out_valid, err_frame;

  modport slave (
    input  s_valid, s_re, s_im, s_last, m_ready,
    output s_ready, xa1, xa2, xa3, xa4, imga1, imga2, imga3, imga4,
           fft_ce, fft_out_valid, err_frame
  );

  modport master (
    output s_valid, s_re, s_im, s_last, m_ready,
    input  s_ready, xa1, xa2, xa3, xa4, imga1, imga2, imga3, imga4,
           fft_ce, fft_out_valid, err_frame
  );
endinterface

// File: rtl/fft_valid_delay.sv
// N-deep 1-bit delay line; aligns a strobe with a fixed-latency pipeline.
module fft_valid_delay #(
  parameter int DEPTH = 2   // must be >= 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] vld_pipe;

  // shift the strobe one stage per cycle; reset drops anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else begin
      vld_pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign dout = vld_pipe[DEPTH-1];
endmodule

// File: rtl/fft4_input_framer.sv
// Packs a serial I/Q stream into 4-sample frames (ping-pong banks) and
// presents each frame in parallel to compff4 with a one-cycle fft_ce.
module fft4_input_framer
  import fft_pkg::FFT_N;
  import fft_pkg::FFT4_LAT;
#(
  parameter int SAMPLE_W = fft_pkg::SAMPLE_W,
  parameter int FFT_LAT  = FFT4_LAT   // must be >= 1
) (
  input logic                 clk,
  input logic                 rst_n,
  fft4_input_framer_if.slave  bus
);
  typedef logic [FFT_N-1:0][SAMPLE_W-1:0] frame_t;

  frame_t [1:0] bank_re, bank_im;
  frame_t       out_re, out_im;
  logic   [1:0] wr_idx;
  logic         wr_bank, rd_bank;
  logic   [1:0] full, full_nxt;
  logic         err_frame, fft_ce;
  logic         acc, wr_done, wr_early, rd;

  // second bank filling blocks input; purely registered, no m_ready path
  assign bus.s_ready = ~(full[0] & full[1]);
  assign acc         = bus.s_valid & bus.s_ready;
  assign wr_done     = acc & (wr_idx == 2'd3);
  assign wr_early    = acc & (wr_idx != 2'd3) & bus.s_last;
  assign rd          = full[rd_bank] & bus.m_ready;

  // sample storage; an aborted partial frame is simply overwritten later
  always_ff @(posedge clk) begin
    if (acc) begin
      bank_re[wr_bank][wr_idx] <= bus.s_re;
      bank_im[wr_bank][wr_idx] <= bus.s_im;
    end
  end

  // a read and a completing write always target different banks
  always_comb begin
    full_nxt = full;
    if (rd)      full_nxt[rd_bank] = 1'b0;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
  end

  // write-side framing, bank flags and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx    <= '0;
      wr_bank   <= 1'b0;
      full      <= '0;
      err_frame <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_done) begin
        wr_idx  <= '0;
        wr_bank <= ~wr_bank;
        if (!bus.s_last) err_frame <= 1'b1;
      end else if (wr_early) begin
        wr_idx    <= '0;   // drop partial frame, resync on next sample
        err_frame <= 1'b1;
      end else if (acc) begin
        wr_idx <= wr_idx + 2'd1;
      end
    end
  end

  // read side: drain oldest full bank into the FFT input registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank <= 1'b0;
      fft_ce  <= 1'b0;
      out_re  <= '0;
      out_im  <= '0;
    end else begin
      fft_ce <= rd;
      if (rd) begin
        out_re  <= bank_re[rd_bank];
        out_im  <= bank_im[rd_bank];
        rd_bank <= ~rd_bank;
      end
    end
  end

  fft_valid_delay #(.DEPTH(FFT_LAT)) u_vld (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (fft_ce),
    .dout (bus.fft_out_valid)
  );

  assign bus.fft_ce    = fft_ce;
  assign bus.err_frame = err_frame;
  assign bus.xa1   = out_re[0];
  assign bus.xa2   = out_re[1];
  assign bus.xa3   = out_re[2];
  assign bus.xa4   = out_re[3];
  assign bus.imga1 = out_im[0];
  assign bus.imga2 = out_im[1];
  assign bus.imga3 = out_im[2];
  assign bus.imga4 = out_im[3];
endmodule

// File: tb/tb_fft4_input_framer.sv
// Scoreboard bench for fft4_input_framer.
module tb_fft4_input_framer;
  import fft_pkg::FFT4_LAT;
  localparam int FFT_LAT = FFT4_LAT;

  typedef struct packed {
    logic [3:0][15:0] re;
    logic [3:0][15:0] im;
  } frm_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft4_input_framer_if #(.SAMPLE_W(16)) bus();

  fft4_input_framer #(.SAMPLE_W(16), .FFT_LAT(FFT_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ce_cnt = 0;
  frm_t sb[$];
  int   ce_q[$];

  // model of input framing
  int               m_idx = 0;
  logic [3:0][15:0] m_re, m_im;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input int re, input int im, input bit last);
    m_re[m_idx] = re[15:0];
    m_im[m_idx] = im[15:0];
    if (m_idx == 3) begin
      sb.push_back('{re: m_re, im: m_im});
      m_idx = 0;
    end else if (last) m_idx = 0;
    else m_idx++;
  endtask

  // drive one sample, wait for acceptance, return 1ns after the accept edge
  task automatic send(input int re, input int im, input bit last);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_re = re[15:0];
    bus.s_im = im[15:0];
    bus.s_last = last;
    while (!bus.s_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) chk("s_ready_timeout", n, 0);
    @(posedge clk);
    model_accept(re, im, last);
    #1 bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit last);
    for (int k = 0; k < 4; k++) send(base + k, -(base + k), last && k == 3);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // output monitor: every fft_ce pops a frame, every out_valid pops a ce time
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fft_ce) begin
        ce_cnt++;
        ce_q.push_back(cyc);
        if (sb.size() == 0) chk("ce_unexpected", 0, 1);
        else begin
          frm_t f;
          f = sb.pop_front();
          chk("xa",   {bus.xa4, bus.xa3, bus.xa2, bus.xa1}, f.re);
          chk("imga", {bus.imga4, bus.imga3, bus.imga2, bus.imga1}, f.im);
        end
      end
      if (bus.fft_out_valid) begin
        if (ce_q.size() == 0) chk("ov_unexpected", 0, 1);
        else chk("ov_lat", cyc - ce_q.pop_front(), FFT_LAT);
      end
    end
  end

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_s_ready"}, bus.s_ready, 1);
    chk({tag, "_fft_ce"}, bus.fft_ce, 0);
    chk({tag, "_ov"}, bus.fft_out_valid, 0);
    chk({tag, "_err"}, bus.err_frame, 0);
    chk({tag, "_xa"}, {bus.xa4, bus.xa3, bus.xa2, bus.xa1}, 0);
    chk({tag, "_imga"}, {bus.imga4, bus.imga3, bus.imga2, bus.imga1}, 0);
  endtask

  initial begin
    int c0;
    bus.s_valid = 0; bus.s_re = 0; bus.s_im = 0; bus.s_last = 0; bus.m_ready = 1;
    #12 chk_zero_outs("rst");
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    // basic frame with latency checks
    send_frame(1, 1);
    chk("ce_early", bus.fft_ce, 0);
    idle(1);
    chk("ce_t1", bus.fft_ce, 1);
    chk("xa_t1", {bus.xa4, bus.xa3, bus.xa2, bus.xa1}, {16'd4, 16'd3, 16'd2, 16'd1});
    chk("imga_t1", {bus.imga4, bus.imga3, bus.imga2, bus.imga1},
        {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF});
    repeat (FFT_LAT - 1) begin
      idle(1);
      chk("ov_early", bus.fft_out_valid, 0);
    end
    idle(1);
    chk("ov_on", bus.fft_out_valid, 1);
    idle(1);
    chk("ov_off", bus.fft_out_valid, 0);
    chk("err_basic", bus.err_frame, 0);

    // backpressure: two banks fill, third frame stalls until m_ready
    bus.m_ready = 1'b0;
    c0 = ce_cnt;
    send_frame(100, 1);
    send_frame(200, 1);
    chk("bp_s_ready_low", bus.s_ready, 0);
    chk("bp_no_ce", ce_cnt - c0, 0);
    fork
      send_frame(300, 1);
      begin idle(3); bus.m_ready = 1'b1; end
    join
    idle(8);
    chk("bp_ce_cnt", ce_cnt - c0, 3);
    chk("bp_s_ready_back", bus.s_ready, 1);
    chk("bp_err", bus.err_frame, 0);

    // missing s_last: frame still delivered, error flagged
    c0 = ce_cnt;
    send_frame(400, 0);
    idle(6);
    chk("miss_ce", ce_cnt - c0, 1);
    chk("miss_err", bus.err_frame, 1);

    // async reset between edges, mid-frame
    send(30, -30, 0);
    send(31, -31, 0);
    #3 rst_n = 1'b0;
    m_idx = 0;
    sb.delete();
    ce_q.delete();
    #1 chk_zero_outs("arst");
    @(negedge clk) rst_n = 1'b1;
    idle(1);
    c0 = ce_cnt;
    send_frame(5, 1);
    idle(6);
    chk("arst_ce", ce_cnt - c0, 1);
    chk("arst_err", bus.err_frame, 0);

    // early s_last on sample 2 drops the partial frame
    c0 = ce_cnt;
    send(20, -20, 0);
    send(21, -21, 1);
    send_frame(10, 1);
    idle(6);
    chk("early_ce", ce_cnt - c0, 1);
    chk("early_err", bus.err_frame, 1);
    idle(3);
    chk("early_err_sticky", bus.err_frame, 1);

    // completing write and draining read in the same cycle
    bus.m_ready = 1'b0;
    c0 = ce_cnt;
    send_frame(40, 1);
    send(50, -50, 0);
    send(51, -51, 0);
    send(52, -52, 0);
    bus.m_ready = 1'b1;
    send(53, -53, 1);
    chk("sim_s_ready", bus.s_ready, 1);
    chk("sim_ce", bus.fft_ce, 1);
    send_frame(60, 1);
    idle(8);
    chk("sim_ce_cnt", ce_cnt - c0, 3);

    chk("sb_empty", sb.size(), 0);
    chk("ceq_empty", ce_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
